// File: rtl/ov7670_config_sequencer.sv
// Walks the OV7670 config ROM from address 0 and issues each {reg,value} word as one SCCB write.
// 16'h00F0 inserts a DELAY_CYCLES wait and 16'hFFFF ends the pass. Defining SCCB_NACK_RETRY_EN enables NACK retry and abort.
module ov7670_config_sequencer #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DELAY_CYCLES = 1_000_000,
    parameter int MAX_RETRIES  = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [15:0]           rom_data_i,
    output logic                  sccb_valid_o,
    input  logic                  sccb_ready_i,
    output logic [7:0]            sccb_reg_o,
    output logic [7:0]            sccb_data_o,
    input  logic                  sccb_done_i,
    input  logic                  sccb_nack_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o
);
    localparam logic [15:0] WORD_END   = 16'hFFFF;
    localparam logic [15:0] WORD_DELAY = 16'h00F0;
    localparam int CNT_W = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic [3:0] {
        IDLE, FETCH, ROMWAIT, DECODE, SEND, WAITDONE, DELAY, NEXT, FINISH, ERROR
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] delay_cnt_q;

`ifdef SCCB_NACK_RETRY_EN
    localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    logic [RETRY_W-1:0] retry_q;
    logic               retry_exhausted;
    assign retry_exhausted = (retry_q == RETRY_W'(MAX_RETRIES));
`else
    localparam int unused_max_retries = MAX_RETRIES;
    logic unused_nack;
    assign unused_nack = sccb_nack_i;
    assign error_o     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (start_i) state_d = FETCH;
            FETCH:    state_d = ROMWAIT;
            ROMWAIT:  state_d = DECODE;
            DECODE: begin
                if (rom_data_i == WORD_END)        state_d = FINISH;
                else if (rom_data_i == WORD_DELAY) state_d = DELAY;
                else                               state_d = SEND;
            end
            SEND:     if (sccb_ready_i) state_d = WAITDONE;
            WAITDONE: begin
                if (sccb_done_i) begin
`ifdef SCCB_NACK_RETRY_EN
                    if (sccb_nack_i) state_d = retry_exhausted ? ERROR : SEND;
                    else             state_d = NEXT;
`else
                    state_d = NEXT;
`endif
                end
            end
            DELAY:    if (delay_cnt_q == '0) state_d = NEXT;
            // The last ROM address is an implicit end marker; the address never wraps.
            NEXT:     state_d = (rom_addr_o == LAST_ADDR) ? FINISH : FETCH;
            FINISH:   state_d = IDLE;
            ERROR:    state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            rom_addr_o   <= '0;
            sccb_valid_o <= 1'b0;
            sccb_reg_o   <= '0;
            sccb_data_o  <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            delay_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            sccb_valid_o <= (state_d == SEND);
            busy_o       <= !(state_d inside {IDLE, FINISH, ERROR});
            if (state_d == FINISH) done_o <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        rom_addr_o <= '0;
                        done_o     <= 1'b0;
                    end
                end
                DECODE: begin
                    delay_cnt_q <= DELAY_LOAD;
                    if (state_d == SEND) begin
                        sccb_reg_o  <= rom_data_i[15:8];
                        sccb_data_o <= rom_data_i[7:0];
                    end
                end
                DELAY: if (delay_cnt_q != '0) delay_cnt_q <= delay_cnt_q - CNT_W'(1);
                NEXT:  if (state_d == FETCH) rom_addr_o <= rom_addr_o + ADDR_WIDTH'(1);
                default: ;
            endcase
        end
    end

`ifdef SCCB_NACK_RETRY_EN
    // rom_addr_o is left on the failing entry after an abort for debug.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            retry_q <= '0;
            error_o <= 1'b0;
        end else begin
            if (state_q == IDLE && start_i) begin
                retry_q <= '0;
                error_o <= 1'b0;
            end else if (state_q == WAITDONE && sccb_done_i) begin
                if (!sccb_nack_i)          retry_q <= '0;
                else if (!retry_exhausted) retry_q <= retry_q + RETRY_W'(1);
            end
            if (state_d == ERROR) error_o <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// Directed plus randomized bench for ov7670_config_sequencer with a ROM model, an SCCB responder and a ROM-walk reference model.
module tb_ov7670_config_sequencer;
    localparam int AW    = 3;
    localparam int DC    = 16;
    localparam int MR    = 3;
    localparam int DEPTH = 1 << AW;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          start_i;
    logic [AW-1:0] rom_addr_o;
    logic [15:0]   rom_data_i;
    logic          sccb_valid_o;
    logic          sccb_ready_i;
    logic [7:0]    sccb_reg_o;
    logic [7:0]    sccb_data_o;
    logic          sccb_done_i;
    logic          sccb_nack_i;
    logic          busy_o;
    logic          done_o;
    logic          error_o;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          start_cyc = 0;
    logic [15:0] rom [DEPTH];
    int          nack_plan [DEPTH];
    logic [23:0] wr_log [$];
    logic [23:0] exp_log [$];
    int          acc_cyc [$];
    int          rise_cyc [$];
    bit          nack_q [$];
    int          hold_cfg = 0;
    bit          hold_rnd = 1'b0;
    int          done_dly = 3;
    bit          addr_wrap = 1'b0;
    bit          exp_done;
    bit          exp_err;
    int          exp_addr;

    ov7670_config_sequencer #(.ADDR_WIDTH(AW), .DELAY_CYCLES(DC), .MAX_RETRIES(MR)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
        .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
        .sccb_valid_o(sccb_valid_o), .sccb_ready_i(sccb_ready_i),
        .sccb_reg_o(sccb_reg_o), .sccb_data_o(sccb_data_o),
        .sccb_done_i(sccb_done_i), .sccb_nack_i(sccb_nack_i),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;
    always @(posedge clk_i) rom_data_i <= rom[rom_addr_o];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: walk the ROM as the rules describe and list every request the master should see.
    task automatic build_model();
        int tries;
        exp_log.delete();
        nack_q.delete();
        exp_done = 1'b1;
        exp_err  = 1'b0;
        exp_addr = DEPTH - 1;
        for (int a = 0; a < DEPTH; a++) begin
            if (rom[a] == 16'hFFFF) begin
                exp_addr = a;
                break;
            end
            if (rom[a] == 16'h00F0) continue;
            for (int n = 0; n < nack_plan[a] && n <= MR; n++) nack_q.push_back(1'b1);
            if (nack_plan[a] <= MR) nack_q.push_back(1'b0);
`ifdef SCCB_NACK_RETRY_EN
            tries = (nack_plan[a] > MR) ? MR + 1 : nack_plan[a] + 1;
`else
            tries = 1;
`endif
            repeat (tries) exp_log.push_back({8'(a), rom[a]});
`ifdef SCCB_NACK_RETRY_EN
            if (nack_plan[a] > MR) begin
                exp_done = 1'b0;
                exp_err  = 1'b1;
                exp_addr = a;
                break;
            end
`endif
        end
    endtask

    task automatic run_pass(input bit mid_start);
        int t;
        wr_log.delete();
        acc_cyc.delete();
        rise_cyc.delete();
        addr_wrap = 1'b0;
        build_model();
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i   = 1'b0;
        start_cyc = cyc;
        check("busy_after_start", busy_o, 1'b1);
        if (mid_start) begin
            repeat (4) @(negedge clk_i);
            start_i = 1'b1;
            @(negedge clk_i);
            start_i = 1'b0;
        end
        t = 0;
        while (!(done_o || error_o) && t < 3000) begin
            @(negedge clk_i);
            t++;
        end
        check("pass_ends", 32'(t < 3000), 1);
        repeat (2) @(negedge clk_i);
        check("n_writes", wr_log.size(), exp_log.size());
        for (int i = 0; i < exp_log.size() && i < wr_log.size(); i++)
            check($sformatf("write%0d", i), wr_log[i], exp_log[i]);
        check("done", done_o, exp_done);
        check("error", error_o, exp_err);
        check("busy_end", busy_o, 1'b0);
        check("addr_end", rom_addr_o, exp_addr);
    endtask

    // SCCB master model: ready after a programmable hold, done a fixed latency after each accept.
    initial begin
        int          done_cnt;
        int          held;
        int          cur_hold;
        logic [15:0] held_word;
        bit          prev_valid;
        bit          prev_busy;
        bit          acc_prev;
        logic [AW-1:0] prev_addr;
        done_cnt = 0; held = 0; cur_hold = 0; held_word = '0;
        prev_valid = 1'b0; prev_busy = 1'b0; acc_prev = 1'b0; prev_addr = '0;
        sccb_ready_i = 1'b0; sccb_done_i = 1'b0; sccb_nack_i = 1'b0;
        forever begin
            @(negedge clk_i);
            sccb_done_i = 1'b0;
            sccb_nack_i = 1'b0;
            if (!rst_ni) begin
                done_cnt = 0; prev_valid = 1'b0; prev_busy = 1'b0; acc_prev = 1'b0;
                sccb_ready_i = 1'b0;
            end else begin
                if (acc_prev) check("valid_drop", sccb_valid_o, 1'b0);
                acc_prev = 1'b0;
                if (done_cnt > 0) begin
                    done_cnt--;
                    if (done_cnt == 0) begin
                        sccb_done_i = 1'b1;
                        sccb_nack_i = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
                    end
                end
                if (sccb_valid_o && !prev_valid) begin
                    rise_cyc.push_back(cyc);
                    held      = 0;
                    held_word = {sccb_reg_o, sccb_data_o};
                    cur_hold  = hold_rnd ? int'($urandom_range(0, 3)) : hold_cfg;
                end
                if (sccb_valid_o) begin
                    if (held > 0) check("hold_stable", {sccb_reg_o, sccb_data_o}, held_word);
                    sccb_ready_i = (held >= cur_hold);
                    if (sccb_ready_i) begin
                        wr_log.push_back({8'(rom_addr_o), sccb_reg_o, sccb_data_o});
                        acc_cyc.push_back(cyc);
                        done_cnt = done_dly;
                        acc_prev = 1'b1;
                    end
                    held++;
                end else begin
                    sccb_ready_i = 1'($urandom_range(0, 1));
                end
                if (busy_o && prev_busy && prev_addr != '0 && rom_addr_o == '0) addr_wrap = 1'b1;
                prev_valid = sccb_valid_o;
                prev_busy  = busy_o;
                prev_addr  = rom_addr_o;
            end
        end
    end

    initial begin
        int t;
        int ffpos;
        rst_ni  = 1'b0;
        start_i = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            rom[a]       = 16'h3344;
            nack_plan[a] = 0;
        end
        repeat (3) @(negedge clk_i);
        check("rst_addr", rom_addr_o, 0);
        check("rst_valid", sccb_valid_o, 0);
        check("rst_reg", sccb_reg_o, 0);
        check("rst_data", sccb_data_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_error", error_o, 0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Two ordinary writes then the end marker.
        rom[0] = 16'h1280; rom[1] = 16'h1204; rom[2] = 16'hFFFF;
        run_pass(1'b0);
        check("n_requests", rise_cyc.size(), 2);
        if (rise_cyc.size() > 0) check("first_req_latency", rise_cyc[0] - start_cyc, 3);
        if (acc_cyc.size() >= 2) check("entry_period", acc_cyc[1] - acc_cyc[0], 4 + 1 + 3);

        // Delay marker: DELAY_CYCLES in DELAY plus the 4-cycle step to the next entry.
        for (int a = 0; a < DEPTH; a++) rom[a] = 16'h3344;
        rom[0] = 16'h00F0; rom[1] = 16'h1180; rom[2] = 16'hFFFF;
        run_pass(1'b0);
        if (rise_cyc.size() > 0) check("delay_latency", rise_cyc[0] - start_cyc, 3 + DC + 4);

        // Ready held low for 10 cycles.
        rom[0] = 16'h3A04; rom[1] = 16'hFFFF;
        hold_cfg = 10;
        run_pass(1'b0);
        hold_cfg = 0;
        check("n_requests_hold", rise_cyc.size(), 1);
        if (acc_cyc.size() > 0 && rise_cyc.size() > 0) check("accept_wait", acc_cyc[0] - rise_cyc[0], 10);

        // No end marker: last address is the implicit end.
        for (int a = 0; a < DEPTH; a++) rom[a] = 16'h0C00;
        run_pass(1'b0);
        check("no_wrap", addr_wrap, 1'b0);

        // Asynchronous reset while a request is pending.
        for (int a = 0; a < DEPTH; a++) rom[a] = 16'h3344;
        rom[0] = 16'h5A5A; rom[1] = 16'hFFFF;
        hold_cfg = 1000;
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        t = 0;
        while (!sccb_valid_o && t < 50) begin
            @(negedge clk_i);
            t++;
        end
        check("valid_seen", sccb_valid_o, 1'b1);
        repeat (3) @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        check("rst_async_valid", sccb_valid_o, 1'b0);
        check("rst_async_busy", busy_o, 1'b0);
        @(negedge clk_i);
        rst_ni   = 1'b1;
        hold_cfg = 0;
        rom[0] = 16'h1280; rom[1] = 16'h1204; rom[2] = 16'hFFFF;
        run_pass(1'b1);

        // NACK handling: four NACKs exhaust the retries, two NACKs then ACK recovers.
        rom[0] = 16'h1111; rom[1] = 16'h2222; rom[2] = 16'hFFFF;
        nack_plan[1] = 4;
        run_pass(1'b0);
        nack_plan[1] = 2;
        run_pass(1'b0);
        nack_plan[1] = 0;

        // Randomized ROM contents, handshake timing and NACK patterns.
        hold_rnd = 1'b1;
        for (int it = 0; it < 6; it++) begin
            for (int a = 0; a < DEPTH; a++) begin
                rom[a]       = ($urandom_range(0, 5) == 0) ? 16'h00F0 : 16'($urandom);
                nack_plan[a] = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 4)) : 0;
            end
            ffpos = $urandom_range(1, DEPTH);
            if (ffpos < DEPTH) rom[ffpos] = 16'hFFFF;
            done_dly = $urandom_range(1, 5);
            run_pass(1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
